wb_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone arbiter.
- Shares one Wishbone slave port (the GPIO/UART peripheral segment) between the MIPS core data port (master 0) and a second requester such as the UART/DMA engine (master 1).
- Round-robin grant, held for the whole cyc_i bus cycle.
- Routes request, write data, read data and ack between the granted master and the slave.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_arb_rr.sv | 56 +++++
 rtl/wb_arbiter_2m.sv | 133 +++++++++++++
 tb/tb_wb_arbiter_2m.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
//   - Default address/data widths
//   - Master index constants
//   - Arbiter state encoding (Idle / Gnt0 / Gnt1)
package wb_arb_pkg;

  localparam int unsigned DefaultAw = 32;
  localparam int unsigned DefaultDw = 32;

  localparam logic Master0 = 1'b0;
  localparam logic Master1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_arb_rr.sv
// Round-robin grant state machine for the two-master Wishbone arbiter.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   req_i    per-master request (master cyc lines)
//   abort_i  force the current grant back to idle (watchdog expiry)
//   gnt_o    one-hot current grant {gnt1, gnt0}
module wb_arb_rr
  import wb_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       abort_i,
  output logic [1:0] gnt_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      // Master 1 counts as last owner so master 0 wins the first contention.
      last_q  <= Master1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (req_i[0] && (!req_i[1] || (last_q == Master1))) begin
          state_d = StGnt0;
          last_d  = Master0;
        end else if (req_i[1]) begin
          state_d = StGnt1;
          last_d  = Master1;
        end
      end
      // Always pass through idle between owners so s_cyc_o drops.
      StGnt0: if (!req_i[0] || abort_i) state_d = StIdle;
      StGnt1: if (!req_i[1] || abort_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_o = {state_q == StGnt1, state_q == StGnt0};
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with round-robin grant held for the
// whole cyc bus cycle. The granted master's request is routed to the slave;
// slave read data is broadcast to both masters, ack only to the owner.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort a grant whose slave
// stalls for TIMEOUT cycles (err pulse to the owner, cyc/stb dropped).
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   m{0,1}_*                  Wishbone master-side ports (dat/adr/we/sel/cyc/stb in,
//                             dat/ack/err out)
//   s_*                       Wishbone slave-side port
//   gnt_o                     one-hot current grant {gnt1, gnt0}
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW      = DefaultAw,
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,

  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,

  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,

  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  output logic [AW-1:0]   s_adr_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic            s_ack_i,

  output logic [1:0]      gnt_o
);

  logic [1:0] gnt;
  logic       abort;

  wb_arb_rr u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   ({m1_cyc_i, m0_cyc_i}),
    .abort_i (abort),
    .gnt_o   (gnt)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            in_gnt;

  assign in_gnt = |gnt;
  assign abort  = in_gnt && (cnt_q == CntW'(TIMEOUT));

  // Counts stalled strobe cycles; idle keeps it at zero so every grant starts fresh.
  always_comb begin
    cnt_d = cnt_q;
    if (!in_gnt || s_ack_i) begin
      cnt_d = '0;
    end else if (s_stb_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign m0_err_o = abort & gnt[0];
  assign m1_err_o = abort & gnt[1];
`else
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT;
  assign abort          = 1'b0;
  assign m0_err_o       = 1'b0;
  assign m1_err_o       = 1'b0;
`endif

  always_comb begin
    s_dat_o = '0;
    s_adr_o = '0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    if (gnt[0]) begin
      s_dat_o = m0_dat_i;
      s_adr_o = m0_adr_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_cyc_o = m0_cyc_i & ~abort;
      s_stb_o = m0_stb_i & ~abort;
    end else if (gnt[1]) begin
      s_dat_o = m1_dat_i;
      s_adr_o = m1_adr_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_cyc_o = m1_cyc_i & ~abort;
      s_stb_o = m1_stb_i & ~abort;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & gnt[0] & ~abort;
  assign m1_ack_o = s_ack_i & gnt[1] & ~abort;
  assign gnt_o    = gnt;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Self-checking bench for wb_arbiter_2m: directed vector table, round-robin
// and watchdog sequences, then random traffic against a behavioural model.
module tb_wb_arbiter_2m;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TbTimeout = 16;
  localparam int          TmoLimit  = 16;
`else
  localparam int unsigned TbTimeout = 255;
  localparam int          TmoLimit  = 0;
`endif

  logic            clk;
  logic            rst;
  logic [1:0][31:0] m_dat;
  logic [1:0][31:0] m_adr;
  logic [1:0]      m_we;
  logic [1:0][3:0] m_sel;
  logic [1:0]      m_cyc;
  logic [1:0]      m_stb;
  logic [31:0]     s_dat_i;
  logic            s_ack;

  logic [31:0] m0_dat_o, m1_dat_o, s_dat_o, s_adr_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;

  wb_arbiter_2m #(
    .AW      (32),
    .DW      (32),
    .TIMEOUT (TbTimeout)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .m0_dat_i (m_dat[0]),
    .m0_dat_o (m0_dat_o),
    .m0_adr_i (m_adr[0]),
    .m0_we_i  (m_we[0]),
    .m0_sel_i (m_sel[0]),
    .m0_cyc_i (m_cyc[0]),
    .m0_stb_i (m_stb[0]),
    .m0_ack_o (m0_ack_o),
    .m0_err_o (m0_err_o),
    .m1_dat_i (m_dat[1]),
    .m1_dat_o (m1_dat_o),
    .m1_adr_i (m_adr[1]),
    .m1_we_i  (m_we[1]),
    .m1_sel_i (m_sel[1]),
    .m1_cyc_i (m_cyc[1]),
    .m1_stb_i (m_stb[1]),
    .m1_ack_o (m1_ack_o),
    .m1_err_o (m1_err_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),
    .s_adr_o  (s_adr_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_ack_i  (s_ack),
    .gnt_o    (gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the bus (-1 = nobody), who owned it last,
  // and how many strobe cycles the current owner has waited without an ack.
  int own   = -1;
  int lst   = 1;
  int stall = 0;

  function automatic bit model_abort();
    return (TmoLimit != 0) && (own >= 0) && (stall == TmoLimit);
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_update();
    bit ab;
    ab = model_abort();
    if (rst) begin
      own = -1; lst = 1; stall = 0;
    end else if (own < 0) begin
      if (m_cyc != 2'b00) begin
        // Contention goes to whoever did not own the bus last time.
        own   = (m_cyc == 2'b11) ? (1 - lst) : (m_cyc[1] ? 1 : 0);
        lst   = own;
        stall = 0;
      end
    end else if (ab || !m_cyc[own]) begin
      own = -1; stall = 0;
    end else if (s_ack) begin
      stall = 0;
    end else if (m_stb[own]) begin
      stall++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic compare_model();
    bit ab;
    ab = model_abort();
    chk("gnt",    gnt_o,    (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00);
    chk("s_cyc",  s_cyc_o,  (own >= 0 && !ab) ? m_cyc[own] : 1'b0);
    chk("s_stb",  s_stb_o,  (own >= 0 && !ab) ? m_stb[own] : 1'b0);
    chk("s_adr",  s_adr_o,  (own >= 0) ? m_adr[own] : 32'h0);
    chk("s_dat",  s_dat_o,  (own >= 0) ? m_dat[own] : 32'h0);
    chk("s_we",   s_we_o,   (own >= 0) ? m_we[own] : 1'b0);
    chk("s_sel",  s_sel_o,  (own >= 0) ? m_sel[own] : 4'h0);
    chk("m0_ack", m0_ack_o, (own == 0) && s_ack && !ab);
    chk("m1_ack", m1_ack_o, (own == 1) && s_ack && !ab);
    chk("m0_err", m0_err_o, (own == 0) && ab);
    chk("m1_err", m1_err_o, (own == 1) && ab);
    chk("m0_rd",  m0_dat_o, s_dat_i);
    chk("m1_rd",  m1_dat_o, s_dat_i);
  endtask

  typedef struct packed {
    logic       rst;
    logic       c0, s0, c1, s1, ack;
    logic [1:0] gnt;
    logic       scyc, a0, a1;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic r, input logic c0, input logic s0, input logic c1,
                              input logic s1, input logic ack, input logic [1:0] g,
                              input logic sc, input logic a0, input logic a1);
    vec_t v;
    v.rst = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack;
    v.gnt = g; v.scyc = sc; v.a0 = a0; v.a1 = a1;
    return v;
  endfunction

  initial begin
    int order_exp[4];
    int got;
    int waited;

    //             rst c0 s0 c1 s1 ack  gnt    scyc a0 a1
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);  // reset state
    tbl[1]  = mk(0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 0);  // m0 request seen
    tbl[2]  = mk(0, 1, 1, 0, 0, 0, 2'b01, 1, 0, 0);  // granted next cycle
    tbl[3]  = mk(0, 1, 1, 0, 0, 1, 2'b01, 1, 1, 0);  // ack forwarded to m0
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0);  // m0 drops cyc
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0);  // stray ack in idle
    tbl[7]  = mk(0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);  // reset restores priority
    tbl[9]  = mk(0, 1, 1, 1, 1, 0, 2'b00, 0, 0, 0);  // simultaneous request
    tbl[10] = mk(0, 1, 1, 1, 1, 0, 2'b01, 1, 0, 0);  // m0 wins
    tbl[11] = mk(0, 1, 1, 1, 1, 1, 2'b01, 1, 1, 0);
    tbl[12] = mk(0, 0, 0, 1, 1, 0, 2'b01, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0);  // mandatory idle gap
    tbl[14] = mk(0, 0, 0, 1, 1, 0, 2'b10, 1, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 1, 1, 2'b10, 1, 0, 1);  // m1 read completes
    tbl[16] = mk(1, 0, 0, 1, 1, 0, 2'b10, 1, 0, 0);  // reset mid-transfer
    tbl[17] = mk(0, 1, 1, 1, 1, 1, 2'b00, 0, 0, 0);  // dropped, no ack
    tbl[18] = mk(0, 1, 1, 1, 1, 0, 2'b01, 1, 0, 0);  // m0 wins after reset

    rst = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    m_dat[0] = 32'h0000_A5A5; m_adr[0] = 32'h0000_0400; m_we[0] = 1'b1; m_sel[0] = 4'hF;
    m_dat[1] = 32'hDEAD_0000; m_adr[1] = 32'h0000_0800; m_we[1] = 1'b0; m_sel[1] = 4'h3;
    s_dat_i = 32'h0000_1234;
    tick();

    for (int i = 0; i < 19; i++) begin
      logic [31:0] e_adr, e_dat;
      logic        e_stb, e_we;
      rst = tbl[i].rst;
      m_cyc = {tbl[i].c1, tbl[i].c0};
      m_stb = {tbl[i].s1, tbl[i].s0};
      s_ack = tbl[i].ack;
      @(negedge clk);
      e_adr = (tbl[i].gnt == 2'b01) ? 32'h400 : (tbl[i].gnt == 2'b10) ? 32'h800 : 32'h0;
      e_dat = (tbl[i].gnt == 2'b01) ? 32'hA5A5 : (tbl[i].gnt == 2'b10) ? 32'hDEAD_0000 : 32'h0;
      e_we  = (tbl[i].gnt == 2'b01);
      e_stb = (tbl[i].gnt == 2'b01) ? tbl[i].s0 : (tbl[i].gnt == 2'b10) ? tbl[i].s1 : 1'b0;
      chk($sformatf("v%0d_gnt", i), gnt_o, tbl[i].gnt);
      chk($sformatf("v%0d_scyc", i), s_cyc_o, tbl[i].scyc);
      chk($sformatf("v%0d_sstb", i), s_stb_o, e_stb);
      chk($sformatf("v%0d_ack0", i), m0_ack_o, tbl[i].a0);
      chk($sformatf("v%0d_ack1", i), m1_ack_o, tbl[i].a1);
      chk($sformatf("v%0d_adr", i), s_adr_o, e_adr);
      chk($sformatf("v%0d_dat", i), s_dat_o, e_dat);
      chk($sformatf("v%0d_we", i), s_we_o, e_we);
      chk($sformatf("v%0d_rd", i), m1_dat_o, 32'h0000_1234);
      chk($sformatf("v%0d_err", i), {m1_err_o, m0_err_o}, 2'b00);
      tick();
    end

    // Round robin: both keep requesting; each owner takes one ack, drops cyc
    // for a single cycle, and re-requests.
    order_exp[0] = 0; order_exp[1] = 1; order_exp[2] = 0; order_exp[3] = 1;
    rst = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    tick();
    rst = 1'b0; m_cyc = 2'b11; m_stb = 2'b11;
    for (int t = 0; t < 4; t++) begin
      got = -1;
      waited = 0;
      while (got < 0 && waited < 20) begin
        @(negedge clk);
        if (gnt_o == 2'b01) got = 0;
        else if (gnt_o == 2'b10) got = 1;
        if (got < 0) begin
          tick();
          waited++;
        end
      end
      chk($sformatf("rr_order%0d", t), got, order_exp[t]);
      if (got < 0) break;
      s_ack = 1'b1;
      tick();
      s_ack = 1'b0;
      m_cyc[got] = 1'b0; m_stb[got] = 1'b0;
      tick();
      m_cyc[got] = 1'b1; m_stb[got] = 1'b1;
    end

`ifdef WB_ARB_TIMEOUT_EN
    begin
      int stalled;
      bit seen;
      rst = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 1'b0;
      tick();
      rst = 1'b0; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
      stalled = 0;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
        @(negedge clk);
        if (m0_err_o) begin
          seen = 1'b1;
          chk("tmo_stb_low", s_stb_o, 1'b0);
          chk("tmo_cyc_low", s_cyc_o, 1'b0);
          chk("tmo_stalls", stalled, 16);
          m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        end else if (s_stb_o) begin
          stalled++;
        end
        tick();
      end
      chk("tmo_seen", seen, 1'b1);
      @(negedge clk);
      chk("tmo_idle", gnt_o, 2'b00);
      chk("tmo_err_once", m0_err_o, 1'b0);
      tick();
    end
`endif

    // Random traffic against the model.
    rst = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    tick();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int m = 0; m < 2; m++) begin
        if (m_cyc[m]) m_cyc[m] = ($urandom_range(0, 5) != 0);
        else          m_cyc[m] = ($urandom_range(0, 2) == 0);
        m_stb[m] = m_cyc[m] ? ($urandom_range(0, 3) != 0) : 1'b0;
        m_dat[m] = $urandom;
        m_adr[m] = $urandom;
        m_we[m]  = $urandom_range(0, 1);
        m_sel[m] = 4'($urandom_range(0, 15));
      end
      s_ack   = ($urandom_range(0, 3) == 0);
      s_dat_i = $urandom;
      @(negedge clk);
      compare_model();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
